irq_pending_latch: RTL and testbench
====================================

// Module: irq_pending_latch
//
// PURPOSE
//   Upstream feeder for the 16-bit priority encoder stage.
//   - Captures rising edges on 16 request lines into sticky pending bits.
//   - Presents the pending vector as the encoder's 16-bit input.
//   - Clears one pending bit per cycle via an index acknowledge; this index is
//     normally the 0..15 code the encoder just produced.
//
// PARAMETERS
//   N_REQ    16   number of request lines; fixed to the encoder input width
//   IDX_W    4    width of ack_idx, equal to clog2(N_REQ)
//
// PORTS
//   clk          in   1   single clock; all state updates on its rising edge
//   rst_n        in   1   reset, asynchronous, active-low
//   req_in       in   16  request levels, synchronous to clk; a 0->1 change is an event
//   ack_valid    in   1   acknowledge strobe, one bit cleared per asserted cycle
//   ack_idx      in   4   index of the pending bit to clear when ack_valid=1
//   mask_we      in   1   mask write strobe (used only with IRQ_MASK_EN)
//   mask_wdata   in   16  new mask value, 1 = enabled (used only with IRQ_MASK_EN)
//   pending_out  out  16  pending & mask; drives the priority encoder input
//   irq_any      out  1   |pending_out
//   ovf_flags    out  16  sticky per-bit flag: event arrived while bit was already pending
//   ack_err      out  1   one-cycle pulse: ack of a bit that was not pending
//
// BEHAVIOUR
//   Reset (rst_n=0, async)
//   - Outputs: pending_out=0, irq_any=0, ovf_flags=0, ack_err=0.
//   - Internal state: pending=0, req_d=0, mask=16'hFFFF.
//   - req_d=0 at reset means any line already high at reset release is captured
//     as an event in the first clock cycle.
//   - Reset asserted mid-operation discards all pending and overflow state immediately.
//   Edge detect
//   - edge = req_in & ~req_d; req_d <= req_in every cycle.
//   - A level held high produces exactly one event.
//   Acknowledge clear
//   - clr = ack_valid ? (1 << ack_idx) : 0.
//   Pending update (per bit, registered)
//   - pending <= (pending & ~clr) | edge.
//   - Set wins over clear: an event and an ack on the same bit in the same cycle
//     leave the bit set.
//   Latency
//   - An event sampled at edge k is visible on pending_out after edge k (1 cycle).
//   - An ack sampled at edge k clears the bit after edge k.
//   - irq_any is the combinational OR of registered state only.
//   Overflow flags
//   - ovf_flags[i] <= 1 when edge[i] & pending[i] & ~clr[i].
//   - Cleared by an ack of bit i, unless a new overflow occurs on bit i in the same cycle.
//   Ack error
//   - ack_err <= ack_valid & ~pending[ack_idx].
//   - The check uses raw pending, ignoring the mask.
//   - pending is unchanged by an erroneous ack.
//   Mask
//   - Masked bits still latch, still count toward overflow, and can still be acked.
//   - Masked bits are hidden from pending_out and irq_any only.
//   No events and no acks: all state holds.
//
// CONFIGURATION
//   IRQ_MASK_EN defined
//   - mask <= mask_wdata on mask_we.
//   - A new mask affects pending_out from the following cycle.
//   IRQ_MASK_EN undefined
//   - mask is constant 16'hFFFF; mask_we and mask_wdata are ignored.
//   - pending_out equals raw pending.
//
// TESTING
//   1. rst_n=0 with req_in=16'hFFFF, then release
//      -> pending_out=16'hFFFF after the first edge, irq_any=1.
//   2. req_in 0 -> 16'h8001
//      -> pending_out=16'h8001 next cycle; ack_idx=15 -> pending_out=16'h0001.
//   3. req_in[3] held high for 5 cycles, ack_idx=3 at cycle 2
//      -> bit 3 set once, cleared, stays 0 while held.
//   4. Bit 2 pending; ack_idx=2 in the same cycle as a new edge on bit 2
//      -> bit 2 stays 1, ovf_flags[2]=0.
//   5. Bit 5 pending, new edge on bit 5 -> ovf_flags[5]=1; ack_idx=5 -> pending[5]=0,
//      ovf_flags[5]=0. Then ack_idx=9 with bit 9 clear -> ack_err=1 for one cycle.
//   6. IRQ_MASK_EN: pending=16'h0001, write mask 16'hFFFE -> pending_out=0, irq_any=0;
//      write 16'hFFFF -> pending_out=16'h0001.

Source files
------------

// File: rtl/irq_pending_latch.sv
// -----------------------------------------------------------------------------
// irq_pending_latch
//   Feeds the 16-bit priority encoder. Rising edges on req_in become sticky
//   pending bits. The encoder's 0..15 code comes back on ack_idx to clear one
//   bit per cycle. Overflow flags mark events that arrived while the bit was
//   already pending. ack_err pulses when an ack names a bit that is not pending.
//
//   Ports
//     clk          system clock, rising-edge active
//     rst_n        asynchronous active-low reset
//     req_in       request levels; a 0->1 change is an event
//     ack_valid    acknowledge strobe
//     ack_idx      index of the pending bit to clear
//     mask_we      mask write strobe        (IRQ_MASK_EN builds only)
//     mask_wdata   new mask, 1 = enabled    (IRQ_MASK_EN builds only)
//     pending_out  pending & mask, drives the encoder input
//     irq_any      OR of pending_out
//     ovf_flags    sticky per-bit overflow flags
//     ack_err      one-cycle pulse on an ack of a non-pending bit
//
//   Build option
//     IRQ_MASK_EN  adds a writable enable mask. Without it the mask is all ones.
// -----------------------------------------------------------------------------
module irq_pending_latch #(
   parameter int N_REQ = 16,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req_in,
   input  logic             ack_valid,
   input  logic [IDX_W-1:0] ack_idx,
   input  logic             mask_we,
   input  logic [N_REQ-1:0] mask_wdata,
   output logic [N_REQ-1:0] pending_out,
   output logic             irq_any,
   output logic [N_REQ-1:0] ovf_flags,
   output logic             ack_err
);

   localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

   logic [N_REQ-1:0] req_d;
   logic [N_REQ-1:0] pending;
   logic [N_REQ-1:0] ovf_q;
   logic             ack_err_q;
   logic [N_REQ-1:0] mask;

   logic [N_REQ-1:0] req_edge;
   logic [N_REQ-1:0] clr;
   logic [N_REQ-1:0] ovf_set;

   assign req_edge = req_in & ~req_d;
   assign clr      = ack_valid ? (ONE_HOT0 << ack_idx) : '0;
   // An ack in the same cycle as the new event consumes the old pending
   // occurrence, so that event is not counted as an overflow.
   assign ovf_set  = req_edge & pending & ~clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_d     <= '0;
         pending   <= '0;
         ovf_q     <= '0;
         ack_err_q <= 1'b0;
      end else begin
         req_d     <= req_in;
         // OR-ing the edge in last gives set priority over clear.
         pending   <= (pending & ~clr) | req_edge;
         ovf_q     <= (ovf_q & ~clr) | ovf_set;
         // Checked against raw pending, so masked bits are still acked cleanly.
         ack_err_q <= ack_valid & ~pending[ack_idx];
      end
   end

`ifdef IRQ_MASK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask <= '1;
      end else if (mask_we) begin
         mask <= mask_wdata;
      end
   end
`else
   assign mask = '1;

   logic unused_mask_inputs;
   assign unused_mask_inputs = mask_we ^ (^mask_wdata);
`endif

   assign pending_out = pending & mask;
   assign irq_any     = |pending_out;
   assign ovf_flags   = ovf_q;
   assign ack_err     = ack_err_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
module tb_irq_pending_latch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] req_in = '0;
   logic        ack_valid = 1'b0;
   logic [3:0]  ack_idx = '0;
   logic        mask_we = 1'b0;
   logic [15:0] mask_wdata = '0;
   logic [15:0] pending_out;
   logic        irq_any;
   logic [15:0] ovf_flags;
   logic        ack_err;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state, one entry per request line.
   bit m_prev [16];
   bit m_pend [16];
   bit m_ovf  [16];
   bit m_mask [16];
   bit m_err;

   irq_pending_latch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_in      (req_in),
      .ack_valid   (ack_valid),
      .ack_idx     (ack_idx),
      .mask_we     (mask_we),
      .mask_wdata  (mask_wdata),
      .pending_out (pending_out),
      .irq_any     (irq_any),
      .ovf_flags   (ovf_flags),
      .ack_err     (ack_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_prev[i] = 1'b0;
         m_pend[i] = 1'b0;
         m_ovf[i]  = 1'b0;
         m_mask[i] = 1'b1;
      end
      m_err = 1'b0;
   endtask

   function automatic logic [15:0] exp_pending_out();
      logic [15:0] v = '0;
      for (int i = 0; i < 16; i++) v[i] = m_pend[i] && m_mask[i];
      return v;
   endfunction

   function automatic logic [15:0] exp_ovf();
      logic [15:0] v = '0;
      for (int i = 0; i < 16; i++) v[i] = m_ovf[i];
      return v;
   endfunction

   task automatic check_all(input string tag);
      logic [15:0] po;
      po = exp_pending_out();
      chk({tag, ".pending_out"}, 32'(pending_out), 32'(po));
      chk({tag, ".irq_any"},     32'(irq_any),     32'(po != 16'h0));
      chk({tag, ".ovf_flags"},   32'(ovf_flags),   32'(exp_ovf()));
      chk({tag, ".ack_err"},     32'(ack_err),     32'(m_err));
   endtask

   // One clock: work out the reference next state from the current inputs,
   // let the edge happen, then compare 1 ns later.
   task automatic step(input string tag);
      bit n_pend [16];
      bit n_ovf  [16];
      bit n_mask [16];
      bit n_err;
      for (int i = 0; i < 16; i++) begin
         bit event_i, ack_i;
         event_i = req_in[i] && !m_prev[i];
         ack_i   = ack_valid && (int'(ack_idx) == i);
         if (event_i)     n_pend[i] = 1'b1;
         else if (ack_i)  n_pend[i] = 1'b0;
         else             n_pend[i] = m_pend[i];
         if (event_i && m_pend[i] && !ack_i) n_ovf[i] = 1'b1;
         else if (ack_i)                     n_ovf[i] = 1'b0;
         else                                n_ovf[i] = m_ovf[i];
`ifdef IRQ_MASK_EN
         n_mask[i] = mask_we ? mask_wdata[i] : m_mask[i];
`else
         n_mask[i] = 1'b1;
`endif
      end
      n_err = ack_valid && !m_pend[ack_idx];
      @(posedge clk);
      for (int i = 0; i < 16; i++) begin
         m_prev[i] = req_in[i];
         m_pend[i] = n_pend[i];
         m_ovf[i]  = n_ovf[i];
         m_mask[i] = n_mask[i];
      end
      m_err = n_err;
      #1;
      check_all(tag);
   endtask

   task automatic idle_inputs();
      ack_valid  = 1'b0;
      ack_idx    = '0;
      mask_we    = 1'b0;
      mask_wdata = '0;
   endtask

   // Called at posedge+1: assert reset, check, release before the next edge.
   task automatic apply_reset(input logic [15:0] req_during);
      req_in = req_during;
      idle_inputs();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("reset");
      chk("reset.pending_out_zero", 32'(pending_out), 32'h0);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      #2;
      check_all("por");

      // 1: lines high through reset are captured on the first edge
      @(posedge clk); #1;
      apply_reset(16'hFFFF);
      step("t1");
      chk("t1.all_pending", 32'(pending_out), 32'hFFFF);
      chk("t1.irq_any", 32'(irq_any), 32'h1);

      // 2: two events then ack of the top bit
      apply_reset(16'h0000);
      step("t2.idle");
      req_in = 16'h8001;
      step("t2.set");
      chk("t2.set_val", 32'(pending_out), 32'h8001);
      ack_valid = 1'b1; ack_idx = 4'd15;
      step("t2.ack");
      chk("t2.ack_val", 32'(pending_out), 32'h0001);
      idle_inputs();

      // 3: held level is one event
      apply_reset(16'h0000);
      step("t3.idle");
      req_in = 16'h0008;
      step("t3.c1");
      ack_valid = 1'b1; ack_idx = 4'd3;
      step("t3.c2");
      idle_inputs();
      for (int k = 0; k < 3; k++) begin
         step("t3.hold");
         chk("t3.bit3_low", 32'(pending_out[3]), 32'h0);
      end

      // 4: set beats clear, no overflow
      apply_reset(16'h0000);
      req_in = 16'h0004; step("t4.set");
      req_in = 16'h0000; step("t4.low");
      req_in = 16'h0004; ack_valid = 1'b1; ack_idx = 4'd2;
      step("t4.both");
      chk("t4.bit2", 32'(pending_out[2]), 32'h1);
      chk("t4.ovf2", 32'(ovf_flags[2]), 32'h0);
      idle_inputs();

      // 5: overflow, ack clears it, ack of idle bit errors for one cycle
      apply_reset(16'h0000);
      req_in = 16'h0020; step("t5.set");
      req_in = 16'h0000; step("t5.low");
      req_in = 16'h0020; step("t5.ovf");
      chk("t5.ovf5", 32'(ovf_flags[5]), 32'h1);
      req_in = 16'h0000; ack_valid = 1'b1; ack_idx = 4'd5;
      step("t5.ack5");
      chk("t5.pend5", 32'(pending_out[5]), 32'h0);
      chk("t5.ovf5_clr", 32'(ovf_flags[5]), 32'h0);
      ack_idx = 4'd9;
      step("t5.ack9");
      chk("t5.ack_err", 32'(ack_err), 32'h1);
      idle_inputs();
      step("t5.after");
      chk("t5.ack_err_pulse", 32'(ack_err), 32'h0);

`ifdef IRQ_MASK_EN
      // 6: mask hides pending bits without dropping them
      apply_reset(16'h0000);
      req_in = 16'h0001; step("t6.set");
      mask_we = 1'b1; mask_wdata = 16'hFFFE;
      step("t6.mask");
      chk("t6.hidden", 32'(pending_out), 32'h0);
      chk("t6.irq_off", 32'(irq_any), 32'h0);
      mask_wdata = 16'hFFFF;
      step("t6.unmask");
      chk("t6.shown", 32'(pending_out), 32'h0001);
      idle_inputs();
`endif

      // Randomized traffic, with occasional asynchronous reset mid-run.
      apply_reset(16'h0000);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 399) == 0) begin
            apply_reset(16'($urandom));
         end
         req_in     = req_in ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
         ack_valid  = ($urandom_range(0, 2) != 0);
         ack_idx    = 4'($urandom_range(0, 15));
         mask_we    = ($urandom_range(0, 9) == 0);
         mask_wdata = 16'($urandom);
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1, "timeout");
   end

endmodule
